// File: rtl/input_conditioner.sv
// input_conditioner: sync chain, debounce and edge pulses for keys/switches; `define AUTO_REPEAT_EN adds key auto-repeat
module input_conditioner #(
  parameter int NUM_KEYS = 4,
  parameter int NUM_SW = 10,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int REPEAT_DELAY = 10,
  parameter int REPEAT_PERIOD = 5
) (
  input  logic                clkIn,
  input  logic                resetIn,
  input  logic [NUM_KEYS-1:0] keysIn,
  input  logic [NUM_SW-1:0]   switchesIn,
  output logic [NUM_KEYS-1:0] keyLevelOut,
  output logic [NUM_KEYS-1:0] keyPressOut,
  output logic [NUM_KEYS-1:0] keyReleaseOut,
  output logic [NUM_KEYS-1:0] keyRepeatOut,
  output logic [NUM_SW-1:0]   switchesOut,
  output logic [NUM_SW-1:0]   switchChangeOut
);
  localparam int N = NUM_KEYS + NUM_SW;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [N-1:0] padNorm, level, pulse, accept;
  logic [N-1:0] syncQ [SYNC_STAGES];
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gBadCfg
    $error("input_conditioner: illegal parameter value");
  end
  assign padNorm = {switchesIn, (KEY_ACTIVE_LOW != 0) ? ~keysIn : keysIn};
  always_ff @(posedge clkIn or posedge resetIn)
    if (resetIn) begin
      for (int i = 0; i < SYNC_STAGES; i++) syncQ[i] <= '0;
    end else begin
      syncQ[0] <= padNorm;
      for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
    end
  for (genvar c = 0; c < N; c++) begin : gCh
    logic s, q, p;
    logic [CW-1:0] cnt;
    assign s = syncQ[SYNC_STAGES-1][c];
    assign accept[c] = (s != q) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign level[c] = q;
    assign pulse[c] = p;
    always_ff @(posedge clkIn or posedge resetIn)
      if (resetIn) begin
        q <= 1'b0;
        p <= 1'b0;
        cnt <= '0;
      end else begin
        p <= accept[c];
        q <= accept[c] ? s : q;
        cnt <= (s == q || accept[c]) ? '0 : cnt + 1'b1;
      end
  end
  assign keyLevelOut = level[NUM_KEYS-1:0];
  assign keyPressOut = pulse[NUM_KEYS-1:0] & level[NUM_KEYS-1:0];
  assign keyReleaseOut = pulse[NUM_KEYS-1:0] & ~level[NUM_KEYS-1:0];
  assign switchesOut = level[N-1:NUM_KEYS];
  assign switchChangeOut = pulse[N-1:NUM_KEYS];
`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rptState_t;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : gRpt
    rptState_t state, stateNext;
    logic [RW-1:0] rCnt, rCntNext;
    logic rpt, rptNext, lvlNext, hitDelay, hitPeriod;
    assign lvlNext = accept[k] ^ level[k];
    assign hitDelay = rCnt == RW'(REPEAT_DELAY - 1);
    assign hitPeriod = rCnt == RW'(REPEAT_PERIOD - 1);
    always_comb begin
      stateNext = state;
      rCntNext = rCnt + 1'b1;
      rptNext = 1'b0;
      if (!lvlNext) begin
        stateNext = IDLE;
        rCntNext = '0;
      end else if (state == IDLE) begin
        stateNext = accept[k] ? DELAY : IDLE;
        rCntNext = '0;
      end else if ((state == DELAY && hitDelay) || (state == REPEAT && hitPeriod)) begin
        stateNext = REPEAT;
        rCntNext = '0;
        rptNext = 1'b1;
      end
    end
    always_ff @(posedge clkIn or posedge resetIn)
      if (resetIn) begin
        state <= IDLE;
        rCnt <= '0;
        rpt <= 1'b0;
      end else begin
        state <= stateNext;
        rCnt <= rCntNext;
        rpt <= rptNext;
      end
    assign keyRepeatOut[k] = rpt;
  end
`else
  assign keyRepeatOut = '0;
`endif
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: table vectors, directed corner sequences and randomized run against a reference model
module tb_input_conditioner;
  localparam int NK = 4, NS = 10, N = NK + NS, SS = 2, DC = 4, RD = 10, RP = 5;
`ifdef AUTO_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif
  logic clkIn = 1'b0, resetIn = 1'b1;
  logic [NK-1:0] keysIn = '0;
  logic [NS-1:0] switchesIn = '1;
  logic [NK-1:0] keyLevelOut, keyPressOut, keyReleaseOut, keyRepeatOut;
  logic [NS-1:0] switchesOut, switchChangeOut;
  int nCmp = 0, nErr = 0;
  logic [N-1:0] hist[$];
  logic [N-1:0] mLevel = '0, mPulse = '0;
  logic [NK-1:0] mRpt = '0;
  int pressEdge[NK] = '{default: -1};
  int edgeNo = 0;

  typedef struct {
    logic [NK-1:0] keys;
    logic [NS-1:0] sw;
    logic [NK-1:0] expKey;
    logic [NS-1:0] expSw;
  } vec_t;

  always #5 clkIn = ~clkIn;

  input_conditioner dut (
    .clkIn(clkIn), .resetIn(resetIn), .keysIn(keysIn), .switchesIn(switchesIn),
    .keyLevelOut(keyLevelOut), .keyPressOut(keyPressOut), .keyReleaseOut(keyReleaseOut),
    .keyRepeatOut(keyRepeatOut), .switchesOut(switchesOut), .switchChangeOut(switchChangeOut)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // A channel flips once the synchronised pad (SS edges old) disagreed with it for DC edges in a row.
  task automatic modelEdge();
    logic [N-1:0] pad;
    pad = {switchesIn, ~keysIn};
    edgeNo++;
    if (resetIn) begin
      hist.delete();
      mLevel = '0;
      mPulse = '0;
      mRpt = '0;
      foreach (pressEdge[k]) pressEdge[k] = -1;
      return;
    end
    hist.push_front(pad);
    while (hist.size() > SS + DC) void'(hist.pop_back());
    for (int c = 0; c < N; c++) begin
      bit all;
      all = 1'b1;
      for (int j = 0; j < DC; j++) begin
        logic v;
        v = (SS + j < hist.size()) ? hist[SS+j][c] : 1'b0;
        if (v == mLevel[c]) all = 1'b0;
      end
      mPulse[c] = all;
      if (all) mLevel[c] = ~mLevel[c];
    end
    for (int k = 0; k < NK; k++) begin
      if (!mLevel[k]) pressEdge[k] = -1;
      else if (mPulse[k]) pressEdge[k] = edgeNo;
      mRpt[k] = RPT_ON && pressEdge[k] >= 0 && edgeNo - pressEdge[k] >= RD
                && (edgeNo - pressEdge[k] - RD) % RP == 0;
    end
  endtask

  task automatic tick();
    @(posedge clkIn);
    modelEdge();
    #1;
    check("outputs", {keyLevelOut, keyPressOut, keyReleaseOut, keyRepeatOut, switchesOut, switchChangeOut},
          {mLevel[NK-1:0], mPulse[NK-1:0] & mLevel[NK-1:0], mPulse[NK-1:0] & ~mLevel[NK-1:0], mRpt,
           mLevel[N-1:NK], mPulse[N-1:NK]});
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    vec_t tbl[6];
    int cnt, at, cnt2, at2;
    tbl[0] = '{keys: 4'b1111, sw: 10'h000, expKey: 4'b0000, expSw: 10'h000};
    tbl[1] = '{keys: 4'b1110, sw: 10'h3FF, expKey: 4'b0001, expSw: 10'h3FF};
    tbl[2] = '{keys: 4'b0101, sw: 10'h155, expKey: 4'b1010, expSw: 10'h155};
    tbl[3] = '{keys: 4'b1010, sw: 10'h2AA, expKey: 4'b0101, expSw: 10'h2AA};
    tbl[4] = '{keys: 4'b0000, sw: 10'h001, expKey: 4'b1111, expSw: 10'h001};
    tbl[5] = '{keys: 4'b1111, sw: 10'h000, expKey: 4'b0000, expSw: 10'h000};
    settle(3);
    check("reset outputs", {keyLevelOut, keyPressOut, keyReleaseOut, keyRepeatOut, switchesOut, switchChangeOut}, 0);
    resetIn = 1'b0;
    settle(5);
    check("post-reset level early", {keyLevelOut, switchesOut}, 0);
    tick();
    check("post-reset key level", keyLevelOut, 4'hF);
    check("post-reset key press", keyPressOut, 4'hF);
    check("post-reset switch change", switchChangeOut, 10'h3FF);
    tick();
    check("post-reset pulses cleared", {keyPressOut, switchChangeOut}, 0);
    for (int i = 0; i < 6; i++) begin
      keysIn = tbl[i].keys;
      switchesIn = tbl[i].sw;
      settle(8);
      check("tbl key level", keyLevelOut, tbl[i].expKey);
      check("tbl switch level", switchesOut, tbl[i].expSw);
      check("tbl pulses idle", {keyPressOut, keyReleaseOut, switchChangeOut}, 0);
    end
    cnt = 0; at = -1;
    keysIn[0] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (keyPressOut[0]) begin cnt++; at = i; end
    end
    check("press count", cnt, 1);
    check("press latency", at, 6);
    cnt = 0; at = -1;
    keysIn[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (keyReleaseOut[0]) begin cnt++; at = i; end
    end
    check("release count", cnt, 1);
    check("release latency", at, 6);
    cnt = 0; cnt2 = 0; at = -1;
    for (int i = 0; i < 20; i++) begin
      keysIn[1] = ((i / 2) % 2) != 0;
      tick();
      if (keyPressOut[1]) cnt++;
      if (keyReleaseOut[1]) cnt2++;
    end
    keysIn[1] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (keyPressOut[1]) begin cnt++; at = i; end
      if (keyReleaseOut[1]) cnt2++;
    end
    check("bounce press count", cnt, 1);
    check("bounce press latency", at, 6);
    check("bounce release count", cnt2, 0);
    keysIn[1] = 1'b1;
    settle(8);
    cnt = 0; at = -1;
    switchesIn[3] = 1'b1;
    settle(3);
    switchesIn[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (switchChangeOut != 0) cnt++;
    end
    check("switch glitch changes", cnt, 0);
    switchesIn[3] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (switchChangeOut[3]) begin cnt++; at = i; end
    end
    check("switch change count", cnt, 1);
    check("switch change latency", at, 6);
    check("switch others unchanged", switchesOut, 10'h008);
    keysIn[2] = 1'b0;
    settle(4);
    #2 resetIn = 1'b1;
    #1 check("async reset clears", {keyLevelOut, keyPressOut, keyReleaseOut, keyRepeatOut, switchesOut, switchChangeOut}, 0);
    settle(2);
    resetIn = 1'b0;
    cnt = 0; at = -1; cnt2 = 0; at2 = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (keyPressOut[2]) begin cnt++; at = i; end
      if (switchChangeOut[3]) begin cnt2++; at2 = i; end
    end
    check("reset relatency press count", cnt, 1);
    check("reset relatency press", at, 6);
    check("reset relatency switch", at2, 6);
    keysIn = 4'hF;
    settle(8);
    cnt = 0; at = -1;
    keysIn[0] = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (keyRepeatOut[0]) begin
        cnt++;
        if (at < 0) at = i;
      end
    end
    check("repeat count", cnt, RPT_ON ? 5 : 0);
    check("first repeat", at, RPT_ON ? 16 : -1);
    keysIn[0] = 1'b1;
    settle(8);
    cnt = 0;
    keysIn[0] = 1'b0;
    settle(8);
    keysIn[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (keyRepeatOut[0]) cnt++;
    end
    check("repeat cancelled in delay", cnt, 0);
    for (int i = 0; i < 3000; i++) begin
      if (resetIn) resetIn = $urandom_range(2) != 0;
      else resetIn = $urandom_range(399) == 0;
      if ($urandom_range(3) != 0) begin
        for (int b = 0; b < NK; b++) if ($urandom_range(5) == 0) keysIn[b] = ~keysIn[b];
        for (int b = 0; b < NS; b++) if ($urandom_range(5) == 0) switchesIn[b] = ~switchesIn[b];
      end
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
